// File: rtl/operand_fetch.sv
// operand_fetch
//   Sequential operand-fetch stage feeding the datapath shifter. Owns the
//   2**ADDR_W-entry general register file. An accepted request reads Rn into
//   the A latch on the next cycle, then Rm into the B latch (together with the
//   captured shift code) on the cycle after. The completed operand set is then
//   held with out_valid until downstream takes it.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_rn, req_rm          source register numbers for A and B
//   req_shift               shift code (00 none, 01 lsl, 10 lsr, 11 asr)
//   w_en, w_num, w_data     register-file write port, accepted in every state
//   out_valid/out_ready     operand-set handshake
//   a_out, b_out, shift_out latched operand set (b_out/shift_out feed shifter)
module operand_fetch #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rn,
  input  logic [ADDR_W-1:0] req_rm,
  input  logic [1:0]        req_shift,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_num,
  input  logic [WIDTH-1:0]  w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  a_out,
  output logic [WIDTH-1:0]  b_out,
  output logic [1:0]        shift_out
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ_A = 2'd1;
  localparam logic [1:0] READ_B = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              accept;

  logic [WIDTH-1:0]  regs [NREG];

  logic [ADDR_W-1:0] rn_q;
  logic [ADDR_W-1:0] rm_q;
  logic [1:0]        shift_q;

  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;

  // Ready in IDLE, or in HOLD when the current set is being consumed this
  // cycle, so a new request can overlap the hand-off.
  always_comb begin
    req_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = READ_A;
      READ_A:  state_nx = READ_B;
      READ_B:  state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = req_valid ? READ_A : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Register file: writes land regardless of FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (w_en) begin
      regs[w_num] <= w_data;
    end
  end

  // Request fields are frozen at accept; req_* may move freely afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
    end else if (accept) begin
      rn_q    <= req_rn;
      rm_q    <= req_rm;
      shift_q <= req_shift;
    end
  end

  // Write-read bypass: a write to the register being read in the same cycle
  // is forwarded so the latch sees the new value rather than the stale one.
  always_comb begin
    rd_a = regs[rn_q];
    rd_b = regs[rm_q];
    if (w_en && (w_num == rn_q)) rd_a = w_data;
    if (w_en && (w_num == rm_q)) rd_b = w_data;
  end

  // Operand latches only load in their read cycle, so HOLD outputs are
  // snapshots unaffected by later writes. out_valid is registered from the
  // next state so it is high exactly while the FSM sits in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == READ_A) begin
        a_out <= rd_a;
      end
      if (state == READ_B) begin
        b_out     <= rd_b;
        shift_out <= shift_q;
      end
      out_valid <= (state_nx == HOLD);
    end
  end

endmodule
